alu_exec_stage: RTL and testbench

Execute stage directly downstream of the operand-select logic. Consumes the selected operand pair (DATA0/DATA1) plus OPCODE/FUNCT3/bit 30 of the instruction, computes the RV32I integer result, and presents it in a result register to the memory/writeback stage under a valid/ready handshake. Add, compare and logic operations take one cycle. Shifts are iterative, one bit per cycle, to keep the datapath small.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_logic_unit.sv | 34 +++
 rtl/alu_exec_stage.sv | 145 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute stage: opcode and funct3
// encodings, the ALU operation enum and the execute FSM state enum.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } exec_state_t;

    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational single-cycle ALU.
//   op_i     : decoded ALU operation
//   data0_i  : first operand
//   data1_i  : second operand
//   result_o : single-cycle result
// Shift ops only reach this unit with a zero shift amount (non-zero shifts
// are iterated by the execute stage), so they simply pass data0_i through.
module alu_logic_unit
    import alu_pkg::*;
(
    input  alu_op_t     op_i,
    input  logic [31:0] data0_i,
    input  logic [31:0] data1_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = data0_i + data1_i;
            ALU_SUB:  result_o = data0_i - data1_i;
            ALU_SLT:  result_o = {31'b0, $signed(data0_i) < $signed(data1_i)};
            ALU_SLTU: result_o = {31'b0, data0_i < data1_i};
            ALU_XOR:  result_o = data0_i ^ data1_i;
            ALU_OR:   result_o = data0_i | data1_i;
            ALU_AND:  result_o = data0_i & data1_i;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result_o = data0_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// RV32I execute stage with valid/ready handshakes on both sides.
//   CLK, RESET          : clock, asynchronous active-high reset
//   IN_VALID / IN_READY : upstream handshake
//   ALU_EN              : 0 = bubble slot, produces RESULT 0 in one cycle
//   DATA0, DATA1        : operands
//   OPCODE, FUNCT3, INSTR_B30 : instruction fields used for decode
//   FLUSH               : synchronous kill of in-flight and held results
//   OUT_VALID / OUT_READY / RESULT : downstream handshake and result
//   BUSY                : high while an iterative shift is in progress
// Add/compare/logic ops complete in one cycle; shifts move one bit per cycle.
module alu_exec_stage
    import alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        ALU_EN,
    input  logic [31:0] DATA0,
    input  logic [31:0] DATA1,
    input  logic [6:0]  OPCODE,
    input  logic [2:0]  FUNCT3,
    input  logic        INSTR_B30,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] RESULT,
    output logic        BUSY
);

    exec_state_t state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    alu_op_t     shop_q, shop_d;

    alu_op_t     op_dec;
    logic [31:0] lu_res;
    logic [31:0] sh_next;
    logic        accept;
    logic        start_shift;

    always_comb begin
        op_dec = ALU_ADD;
        if (OPCODE == OPC_OP || OPCODE == OPC_OP_IMM) begin
            case (FUNCT3)
                F3_ADD:  op_dec = (OPCODE == OPC_OP && INSTR_B30) ? ALU_SUB : ALU_ADD;
                F3_SLL:  op_dec = ALU_SLL;
                F3_SLT:  op_dec = ALU_SLT;
                F3_SLTU: op_dec = ALU_SLTU;
                F3_XOR:  op_dec = ALU_XOR;
                F3_SR:   op_dec = INSTR_B30 ? ALU_SRA : ALU_SRL;
                F3_OR:   op_dec = ALU_OR;
                F3_AND:  op_dec = ALU_AND;
                default: op_dec = ALU_ADD;
            endcase
        end
    end

    alu_logic_unit u_logic (
        .op_i     (op_dec),
        .data0_i  (DATA0),
        .data1_i  (DATA1),
        .result_o (lu_res)
    );

    // Held off during reset so the first ready cycle follows deassertion.
    assign IN_READY    = !RESET && (state_q == IDLE) && (!out_valid_q || OUT_READY) && !FLUSH;
    assign accept      = IN_VALID && IN_READY;
    assign start_shift = ALU_EN && is_shift(op_dec) && (DATA1[4:0] != 5'd0);

    always_comb begin
        case (shop_q)
            ALU_SLL: sh_next = {shreg_q[30:0], 1'b0};
            ALU_SRA: sh_next = {shreg_q[31], shreg_q[31:1]};
            default: sh_next = {1'b0, shreg_q[31:1]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        shop_d      = shop_q;
        if (FLUSH) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            // Consumption first; a result written this cycle overrides it.
            if (out_valid_q && OUT_READY) out_valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (start_shift) begin
                            state_d = SHIFT;
                            shreg_d = DATA0;
                            cnt_d   = DATA1[4:0];
                            shop_d  = op_dec;
                        end else begin
                            result_d    = ALU_EN ? lu_res : '0;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shreg_d = sh_next;
                    cnt_d   = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_d    = sh_next;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            shop_q      <= ALU_SLL;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            shop_q      <= shop_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign BUSY      = (state_q == SHIFT);

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic        ALU_EN;
    logic [31:0] DATA0, DATA1;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic        INSTR_B30;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic        BUSY;

    int tests = 0;
    int fails = 0;

    alu_exec_stage dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ALU_EN(ALU_EN), .DATA0(DATA0), .DATA1(DATA1), .OPCODE(OPCODE),
        .FUNCT3(FUNCT3), .INSTR_B30(INSTR_B30), .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, LUI = 7'b0110111, AUI = 7'b0010111;

    // Reference: RV32I integer semantics straight from the field values.
    function automatic logic [31:0] model(input logic en, input logic [6:0] opc,
                                          input logic [2:0] f3, input logic b30,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sr;
        int sh;
        sa = a;
        sh = int'(b % 32);
        sr = sa >>> sh;
        if (!en) return 32'h0;
        if (opc == OP || opc == OPI) begin
            case (f3)
                3'd0: return (opc == OP && b30) ? a - b : a + b;
                3'd1: return a << sh;
                3'd2: return (sa < $signed(b)) ? 32'h1 : 32'h0;
                3'd3: return (a < b) ? 32'h1 : 32'h0;
                3'd4: return a ^ b;
                3'd5: return b30 ? sr : (a >> sh);
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        return a + b;
    endfunction

    // Edges from accept to OUT_VALID observed.
    function automatic int model_lat(input logic en, input logic [6:0] opc,
                                     input logic [2:0] f3, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if (en && (opc == OP || opc == OPI) && (f3 == 3'd1 || f3 == 3'd5) && sh != 0)
            return sh + 1;
        return 1;
    endfunction

    task automatic set_op(input logic en, input logic [6:0] opc, input logic [2:0] f3,
                          input logic b30, input logic [31:0] a, input logic [31:0] b);
        ALU_EN = en; OPCODE = opc; FUNCT3 = f3; INSTR_B30 = b30; DATA0 = a; DATA1 = b;
    endtask

    // Drives one op through the handshake; reports latency, busy cycles,
    // cycles with IN_READY high while BUSY, and the result.
    task automatic issue(input logic en, input logic [6:0] opc, input logic [2:0] f3,
                         input logic b30, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc, output int rdy_bad,
                         output logic [31:0] res);
        int n;
        set_op(en, opc, f3, b30, a, b);
        IN_VALID = 1'b1;
        n = 0;
        while (!IN_READY && n < 100) begin @(posedge CLK); #1; n++; end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 1; busy_cyc = 0; rdy_bad = 0;
        while (!OUT_VALID && lat < 100) begin
            if (BUSY) busy_cyc++;
            if (BUSY && IN_READY) rdy_bad++;
            @(posedge CLK); #1;
            lat++;
        end
        res = RESULT;
    endtask

    task automatic test_reset;
        RESET = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
        set_op(1'b1, OP, 3'd0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
        tests++; if (RESULT !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 00000000", RESULT); end
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", BUSY); end
        tests++; if (IN_READY !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", IN_READY); end
        RESET = 1'b0;
        @(posedge CLK); #1;
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_ready_after got %b want 1", IN_READY); end
    endtask

    task automatic test_directed;
        int lat, bc, rb;
        logic [31:0] r;
        issue(1'b1, OP, 3'd0, 1'b0, 32'd5, 32'd7, lat, bc, rb, r);
        tests++; if (r !== 32'h0000000C) begin fails++; $display("FAIL add_result got %h want 0000000c", r); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL add_latency got %0d want 1", lat); end
        issue(1'b1, OP, 3'd0, 1'b1, 32'd3, 32'd5, lat, bc, rb, r);
        tests++; if (r !== 32'hFFFFFFFE) begin fails++; $display("FAIL sub_result got %h want fffffffe", r); end
        issue(1'b1, OPI, 3'd0, 1'b1, 32'd3, 32'd5, lat, bc, rb, r);
        tests++; if (r !== 32'h00000008) begin fails++; $display("FAIL addi_b30_result got %h want 00000008", r); end
        issue(1'b1, OP, 3'd5, 1'b1, 32'h80000000, 32'd4, lat, bc, rb, r);
        tests++; if (r !== 32'hF8000000) begin fails++; $display("FAIL sra_result got %h want f8000000", r); end
        tests++; if (bc !== 4) begin fails++; $display("FAIL sra_busy_cycles got %0d want 4", bc); end
        tests++; if (rb !== 0) begin fails++; $display("FAIL sra_ready_while_busy got %0d want 0", rb); end
        tests++; if (lat !== 5) begin fails++; $display("FAIL sra_latency got %0d want 5", lat); end
        issue(1'b1, OP, 3'd5, 1'b0, 32'h80000000, 32'd4, lat, bc, rb, r);
        tests++; if (r !== 32'h08000000) begin fails++; $display("FAIL srl_result got %h want 08000000", r); end
        issue(1'b1, OP, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1, lat, bc, rb, r);
        tests++; if (r !== 32'h1) begin fails++; $display("FAIL slt_result got %h want 00000001", r); end
        issue(1'b1, OP, 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1, lat, bc, rb, r);
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL sltu_result got %h want 00000000", r); end
        issue(1'b1, OP, 3'd1, 1'b0, 32'h1234ABCD, 32'hFFFFFFE0, lat, bc, rb, r);
        tests++; if (r !== 32'h1234ABCD) begin fails++; $display("FAIL sll_shamt0_result got %h want 1234abcd", r); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL sll_shamt0_latency got %0d want 1", lat); end
        issue(1'b0, OP, 3'd0, 1'b0, 32'h11111111, 32'h22222222, lat, bc, rb, r);
        tests++; if (r !== 32'h0 || lat !== 1) begin fails++; $display("FAIL bubble got %h lat %0d want 00000000 lat 1", r, lat); end
    endtask

    task automatic test_random;
        int lat, bc, rb;
        logic [31:0] r, a, b, exp;
        logic [6:0] opc;
        logic [2:0] f3;
        logic en, b30;
        logic [6:0] opcs [6];
        opcs = '{OP, OPI, LD, ST, LUI, AUI};
        for (int i = 0; i < 150; i++) begin
            opc = opcs[(i % 3 == 0) ? $urandom_range(0, 5) : $urandom_range(0, 1)];
            f3  = 3'($urandom_range(0, 7));
            b30 = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) != 0);
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
            exp = model(en, opc, f3, b30, a, b);
            issue(en, opc, f3, b30, a, b, lat, bc, rb, r);
            tests++;
            if (r !== exp || lat !== model_lat(en, opc, f3, b)) begin
                fails++;
                $display("FAIL random_%0d opc %b f3 %0d b30 %b en %b a %h b %h got %h lat %0d want %h lat %0d",
                         i, opc, f3, b30, en, a, b, r, lat, exp, model_lat(en, opc, f3, b));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q [$];
        logic [31:0] a, b, exp;
        logic [2:0] f3s [6];
        logic [2:0] f3;
        logic b30;
        f3s = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom;
            f3 = f3s[$urandom_range(0, 5)];
            b30 = 1'($urandom_range(0, 1));
            set_op(1'b1, OP, f3, b30, a, b);
            exp_q.push_back(model(1'b1, OP, f3, b30, a, b));
            IN_VALID = 1'b1;
            tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d got %b want 1", i, IN_READY); end
            @(posedge CLK); #1;
            exp = exp_q.pop_front();
            tests++;
            if (OUT_VALID !== 1'b1 || RESULT !== exp) begin
                fails++;
                $display("FAIL b2b_result_%0d got v%b %h want v1 %h", i, OUT_VALID, RESULT, exp);
            end
        end
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure;
        int lat, bc, rb;
        logic [31:0] r;
        OUT_READY = 1'b0;
        issue(1'b1, OP, 3'd4, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, lat, bc, rb, r);
        tests++; if (r !== 32'hAAAAAAAA) begin fails++; $display("FAIL bp_first got %h want aaaaaaaa", r); end
        set_op(1'b1, OP, 3'd0, 1'b0, 32'd100, 32'd23);
        IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || RESULT !== 32'hAAAAAAAA) begin
                fails++;
                $display("FAIL bp_hold_%0d got rdy %b v %b %h want rdy 0 v 1 aaaaaaaa", i, IN_READY, OUT_VALID, RESULT);
            end
            @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
        #1;
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", IN_READY); end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        tests++;
        if (OUT_VALID !== 1'b1 || RESULT !== 32'd123) begin
            fails++; $display("FAIL bp_new_result got v %b %h want v 1 0000007b", OUT_VALID, RESULT);
        end
        @(posedge CLK); #1;
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", OUT_VALID); end
    endtask

    task automatic test_flush;
        int lat, bc, rb, seen;
        logic [31:0] r;
        OUT_READY = 1'b1;
        issue(1'b1, OP, 3'd6, 1'b0, 32'h000000F0, 32'h0000000F, lat, bc, rb, r);
        @(posedge CLK); #1;
        set_op(1'b1, OP, 3'd5, 1'b0, 32'hFFFF0000, 32'd8);
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        FLUSH = 1'b1;
        #1;
        tests++; if (IN_READY !== 1'b0) begin fails++; $display("FAIL flush_ready_during got %b want 0", IN_READY); end
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        #1;
        tests++;
        if (BUSY !== 1'b0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || RESULT !== 32'h000000FF) begin
            fails++;
            $display("FAIL flush_after got busy %b v %b rdy %b %h want busy 0 v 0 rdy 1 000000ff",
                     BUSY, OUT_VALID, IN_READY, RESULT);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reset_midshift;
        int lat, bc, rb;
        logic [31:0] r;
        issue(1'b1, OP, 3'd0, 1'b0, 32'h1000, 32'h0234, lat, bc, rb, r);
        @(posedge CLK); #1;
        set_op(1'b1, OP, 3'd1, 1'b0, 32'h00000003, 32'd8);
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL midshift_busy got %b want 1", BUSY); end
        RESET = 1'b1;
        #1;
        tests++;
        if (BUSY !== 1'b0 || OUT_VALID !== 1'b0 || RESULT !== 32'h0 || IN_READY !== 1'b0) begin
            fails++;
            $display("FAIL midshift_reset got busy %b v %b %h rdy %b want 0 0 00000000 0",
                     BUSY, OUT_VALID, RESULT, IN_READY);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL midshift_ready_after got %b want 1", IN_READY); end
        issue(1'b1, OP, 3'd7, 1'b0, 32'hDEADBEEF, 32'h0000FFFF, lat, bc, rb, r);
        tests++; if (r !== 32'h0000BEEF) begin fails++; $display("FAIL post_reset_and got %h want 0000beef", r); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midshift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
